// File: rtl/cpu_pkg.sv
// Shared core definitions: funct3 width/sign codes, major opcodes,
// LSU state encoding and the base byte-enable helper.
package cpu_pkg;

  localparam int XLEN = 64;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Store funct3 codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  // Major opcodes
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // LSU state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_WAIT_R = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // Unshifted byte enables for an access size (funct3[1:0])
  function automatic logic [7:0] be_base(input logic [1:0] size);
    logic [7:0] be;
    case (size)
      2'd0:    be = 8'h01;
      2'd1:    be = 8'h03;
      2'd2:    be = 8'h0F;
      2'd3:    be = 8'hFF;
      default: be = 8'h00;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment: byte-enable and store-data shifting,
// misalignment / illegal funct3 detection, load lane extraction and extension.
module lsu_align
  import cpu_pkg::*;
(
  input  logic [2:0]      func3,
  input  logic            is_load,
  input  logic [2:0]      offset,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [7:0]      be,
  output logic [XLEN-1:0] wdata_sh,
  output logic            misalign,
  output logic            illegal,
  output logic [XLEN-1:0] ldata
);

  logic [XLEN-1:0] lane_s;

  // Shift store-side data/enables into the addressed lanes and classify the access
  always_comb begin
    be       = be_base(func3[1:0]) << offset;
    wdata_sh = wdata << {offset, 3'b000};
    case (func3[1:0])
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = offset[0];
      2'd2:    misalign = |offset[1:0];
      2'd3:    misalign = |offset;
      default: misalign = 1'b0;
    endcase
    if (is_load) begin
      illegal = (func3 == 3'b111);
    end else begin
      illegal = func3[2];
    end
  end

  // Pull the addressed lane down to bit 0 and sign/zero extend it
  always_comb begin
    lane_s = rdata >> {offset, 3'b000};
    case (func3)
      F3_LB:   ldata = {{56{lane_s[7]}},  lane_s[7:0]};
      F3_LH:   ldata = {{48{lane_s[15]}}, lane_s[15:0]};
      F3_LW:   ldata = {{32{lane_s[31]}}, lane_s[31:0]};
      F3_LD:   ldata = lane_s;
      F3_LBU:  ldata = {56'd0, lane_s[7:0]};
      F3_LHU:  ldata = {48'd0, lane_s[15:0]};
      F3_LWU:  ldata = {32'd0, lane_s[31:0]};
      default: ldata = {XLEN{1'b0}};
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding data-memory access with req/gnt then
// rvalid handshake; returns extended load data or store completion.
module lsu
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_is_load,
  input  logic [2:0]      req_func3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [4:0]      req_rd,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [7:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rsp_valid,
  output logic            rsp_we,
  output logic [4:0]      rsp_rd,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_err
);

  logic [1:0]      state_r;
  logic            ready_r;
  logic            is_load_r;
  logic [2:0]      func3_r;
  logic [2:0]      offset_r;
  logic [4:0]      rd_r;

  logic [2:0]      al_func3_s;
  logic            al_is_load_s;
  logic [2:0]      al_offset_s;
  logic [7:0]      al_be_s;
  logic [XLEN-1:0] al_wdata_s;
  logic            al_misalign_s;
  logic            al_illegal_s;
  logic [XLEN-1:0] al_ldata_s;

  // In IDLE the aligner looks at the incoming request, otherwise at the captured one
  always_comb begin
    if (state_r == ST_IDLE) begin
      al_func3_s   = req_func3;
      al_is_load_s = req_is_load;
      al_offset_s  = req_addr[2:0];
    end else begin
      al_func3_s   = func3_r;
      al_is_load_s = is_load_r;
      al_offset_s  = offset_r;
    end
  end

  lsu_align u_align (
    .func3    (al_func3_s),
    .is_load  (al_is_load_s),
    .offset   (al_offset_s),
    .wdata    (req_wdata),
    .rdata    (mem_rdata),
    .be       (al_be_s),
    .wdata_sh (al_wdata_s),
    .misalign (al_misalign_s),
    .illegal  (al_illegal_s),
    .ldata    (al_ldata_s)
  );

  // Transaction FSM with all memory and response outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      ready_r   <= 1'b1;
      is_load_r <= 1'b0;
      func3_r   <= 3'd0;
      offset_r  <= 3'd0;
      rd_r      <= 5'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= {XLEN{1'b0}};
      mem_be    <= 8'h00;
      mem_wdata <= {XLEN{1'b0}};
      rsp_valid <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_rd    <= 5'd0;
      rsp_data  <= {XLEN{1'b0}};
      rsp_err   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            is_load_r <= req_is_load;
            func3_r   <= req_func3;
            offset_r  <= req_addr[2:0];
            rd_r      <= req_rd;
            ready_r   <= 1'b0;
            if (al_misalign_s || al_illegal_s) begin
              // Faulting access never reaches memory
              state_r   <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_we    <= 1'b0;
              rsp_rd    <= req_is_load ? req_rd : 5'd0;
              rsp_data  <= {XLEN{1'b0}};
            end else begin
              state_r   <= ST_REQ;
              mem_req   <= 1'b1;
              mem_we    <= ~req_is_load;
              mem_addr  <= {req_addr[XLEN-1:3], 3'b000};
              mem_be    <= al_be_s;
              mem_wdata <= req_is_load ? {XLEN{1'b0}} : al_wdata_s;
            end
          end else begin
            ready_r <= 1'b1;
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {XLEN{1'b0}};
            mem_be    <= 8'h00;
            mem_wdata <= {XLEN{1'b0}};
            if (is_load_r) begin
              state_r <= ST_WAIT_R;
            end else begin
              state_r   <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_we    <= 1'b0;
              rsp_rd    <= 5'd0;
              rsp_data  <= {XLEN{1'b0}};
            end
          end else begin
            state_r <= ST_REQ;
          end
        end
        ST_WAIT_R: begin
          if (mem_rvalid) begin
            state_r   <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_we    <= (rd_r != 5'd0);
            rsp_rd    <= rd_r;
            rsp_data  <= al_ldata_s;
          end else begin
            state_r <= ST_WAIT_R;
          end
        end
        ST_RESP: begin
          state_r   <= ST_IDLE;
          ready_r   <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_we    <= 1'b0;
          rsp_rd    <= 5'd0;
          rsp_data  <= {XLEN{1'b0}};
        end
        default: begin
          state_r   <= ST_IDLE;
          ready_r   <= 1'b1;
          mem_req   <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = ready_r;

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the RV64 core. Accepts one memory operation per transaction from the execute stage: effective address from the ALU, store data from rs2, width/sign from funct3. Drives a single-outstanding data-memory port with a request/grant then read-valid handshake, and returns sign/zero-extended load data or a store completion to writeback. It consumes the decoder's load/store classification and is the memory-side responder for the accesses the decoder initiates.

## Interface
- XLEN, 64, data and address width
- clk  in  1  core clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  execute stage presents an operation
- req_ready  out  1  LSU can accept; high only in IDLE
- req_is_load  in  1  1 = load, 0 = store
- req_func3  in  3  RV64 funct3 width/sign code
- req_addr  in  XLEN  effective address (rs1 + imm)
- req_wdata  in  XLEN  store data, unshifted (rs2)
- req_rd  in  5  load destination register
- mem_req  out  1  memory request, held until mem_gnt
- mem_we  out  1  1 = write
- mem_addr  out  XLEN  doubleword-aligned address ({req_addr[XLEN-1:3],3'b0})
- mem_be  out  8  byte enables, shifted by addr[2:0]
- mem_wdata  out  XLEN  store data shifted to byte lane addr[2:0]
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid; earliest the cycle after mem_gnt
- mem_rdata  in  XLEN  read doubleword
- rsp_valid  out  1  one-cycle completion pulse, no backpressure
- rsp_we  out  1  write rd (successful load with rd != 0)
- rsp_rd  out  5  destination register
- rsp_data  out  XLEN  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal funct3

## Operation
- States: IDLE, REQ, WAIT_R, RESP.
- IDLE: req_ready=1. On req_valid, capture all req_* fields. Illegal funct3 (load 111; store 1xx) or misaligned address (H: addr[0]!=0, W: addr[1:0]!=0, D: addr[2:0]!=0) -> RESP with err=1, no memory access. Otherwise -> REQ.
- REQ: mem_req=1 with stable addr/be/wdata/we. mem_gnt: store -> RESP; load -> WAIT_R. No gnt -> stay.
- WAIT_R: on mem_rvalid, capture extracted data -> RESP.
- RESP: rsp_valid=1 for exactly one cycle -> IDLE.
- Byte enables before shift: B 0x01, H 0x03, W 0x0F, D 0xFF; mem_be = base << addr[2:0].
- Store data: mem_wdata = req_wdata << (8*addr[2:0]).
- Load extract: lane = mem_rdata >> (8*addr[2:0]); LB/LH/LW sign-extend bit 7/15/31; LBU/LHU/LWU zero-extend; LD unchanged.
- rsp_we = load & ~err & (rd != 0). rsp_rd = captured rd for loads, 0 for stores.
- mem_rvalid outside WAIT_R and mem_gnt outside REQ are ignored.

## Timing
- Reset (async assert, sync release): state IDLE; req_ready=1; mem_req, mem_we, mem_be, mem_addr, mem_wdata, rsp_* all 0.
- Accept at edge 0 -> mem_req high in cycle 1.
- Store, gnt in cycle 1 -> rsp_valid in cycle 2 (min latency 2).
- Load, gnt in cycle 1, rvalid in cycle 2 -> rsp_valid in cycle 3 (min latency 3).
- Error -> rsp_valid in cycle 1, mem_req never asserted.
- Each cycle gnt/rvalid is delayed adds exactly one cycle.
- Next req accepted the cycle after rsp_valid (RESP->IDLE); no overlap, one outstanding access.
- Reset mid-REQ/WAIT_R: outputs drop immediately, transaction is lost, any late rvalid is ignored in IDLE.

## Structure
- Shared package cpu_pkg: funct3 codes (LB..LWU, SB..SD), opcode constants LOAD/STORE, LSU state encoding.
- Sub-module lsu_align (combinational): be/wdata shift, misalign/illegal check, load extract/extend. Reused by the decoder's store byte-enable path.

## Test plan
- SD addr 0x1000, wdata 0x1122334455667788, gnt in cycle 1 -> mem_be 0xFF, mem_addr 0x1000, rsp_valid cycle 2, rsp_we 0.
- SB addr 0x1003, wdata 0xAB -> mem_be 0x08, mem_wdata 0x00000000AB000000, mem_addr 0x1000.
- LB addr 0x2005, rd 7, rdata 0x0000_8000_0000_0000, gnt delayed 2 cycles, rvalid 3 cycles later -> rsp_data 0xFFFF_FFFF_FFFF_FF80, rsp_rd 7, rsp_we 1. Same with LBU -> 0x80.
- LW addr 0x2002 -> rsp_err 1, rsp_valid cycle 1, mem_req stays 0; load funct3 111 -> same.
- LD rd 0 -> rsp_we 0, rsp_data = rdata.
- Reset asserted in WAIT_R, rvalid pulses after release -> no rsp_valid, req_ready 1, next SW completes normally.
